// File: rtl/rv32im_prefetch_queue_if.sv
// rv32im_prefetch_queue_if: Wishbone read master plus arbiter request/grant
// used by the instruction prefetch queue.
interface rv32im_prefetch_queue_if #(
    parameter int XLEN = 32
);
    logic            ctrl_req_o;
    logic            ctrl_grant_i;
    logic [XLEN-1:0] master_dat_i;
    logic            ack_i;
    logic            err_i;
    logic [XLEN-3:0] adr_o;
    logic            cyc_o;
    logic            stb_o;
    logic [3:0]      sel_o;

    modport master (
        output ctrl_req_o, adr_o, cyc_o, stb_o, sel_o,
        input  ctrl_grant_i, master_dat_i, ack_i, err_i
    );

    modport slave (
        input  ctrl_req_o, adr_o, cyc_o, stb_o, sel_o,
        output ctrl_grant_i, master_dat_i, ack_i, err_i
    );
endinterface

// File: rtl/rv32im_prefetch_queue.sv
// rv32im_prefetch_queue: sequential instruction prefetch into a DEPTH-entry FIFO
// with redirect flush, boot/interrupt vector lookup and per-entry bus fault flag.
module rv32im_prefetch_queue #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   redirect_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [ILEN-1:0]        instruction_o,
    output logic [XLEN-1:0]        instr_pc_o,
    output logic                   fault_o,
    output logic [$clog2(DEPTH):0] level_o,
    input  logic                   interrupt_trigger_i,
    input  logic [XLEN-1:0]        vtable_addr_i,
    input  logic [XLEN-1:0]        vtable_offset_i,
    output logic [XLEN-1:0]        interrupt_pc_o,
    output logic                   interrupt_pc_write_o,
    rv32im_prefetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {BOOT, IDLE, FETCH, VECTOR, DISCARD} state_t;

    state_t          r_state;
    logic            r_stb;
    logic            r_irq_pending;
    logic            r_redir_v;
    logic            r_int_wr;
    logic [XLEN-3:0] r_adr;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_redir_pc;
    logic [XLEN-1:0] r_int_pc;
    logic [AW:0]     r_level;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [ILEN-1:0] r_mem_ins [DEPTH];
    logic [XLEN-1:0] r_mem_pc  [DEPTH];
    logic [DEPTH-1:0] r_mem_flt;

    logic            w_term;
    logic            w_abort;
    logic            w_rd_v;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic [XLEN-1:0] w_redir_pc;
    logic [XLEN-1:0] w_rd_pc;
    logic [XLEN-1:0] w_vec_sum;

    always_comb begin
        w_term     = r_stb & bus.ctrl_grant_i & (bus.ack_i | bus.err_i);
        w_abort    = redirect_i | interrupt_trigger_i;
        w_redir_pc = redirect_pc_i & ~XLEN'(3);
        w_rd_v     = redirect_i | r_redir_v;
        w_rd_pc    = redirect_i ? w_redir_pc : r_redir_pc;
        w_vec_sum  = vtable_addr_i + vtable_offset_i;
        w_push     = (r_state == FETCH) & w_term & ~w_abort;
        w_flush    = ((r_state == IDLE) & (r_irq_pending | redirect_i))
                   | (w_term & ((r_state == VECTOR) | (r_state == DISCARD) | ((r_state == FETCH) & w_abort)));
        w_pop      = pop_i & (r_level != '0) & ~w_flush;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state       <= BOOT;
            r_stb         <= 1'b0;
            r_adr         <= '0;
            r_irq_pending <= 1'b0;
            r_redir_v     <= 1'b0;
            r_redir_pc    <= '0;
            r_fetch_pc    <= '0;
            r_int_pc      <= '0;
            r_int_wr      <= 1'b0;
            r_level       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_int_wr      <= 1'b0;
            r_irq_pending <= interrupt_trigger_i | (r_irq_pending & ~((r_state == VECTOR) & w_term));
            if (w_flush) begin
                r_level <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
            end else begin
                r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
                r_wptr  <= r_wptr + AW'(w_push);
                r_rptr  <= r_rptr + AW'(w_pop);
            end
            case (r_state)
                BOOT: begin
                    r_stb   <= 1'b1;
                    r_adr   <= (XLEN-2)'(w_vec_sum >> 2);
                    r_state <= VECTOR;
                end
                IDLE: begin
                    if (r_irq_pending) begin
                        r_stb   <= 1'b1;
                        r_adr   <= (XLEN-2)'(w_vec_sum >> 2);
                        r_state <= VECTOR;
                    end else if (redirect_i) begin
                        r_fetch_pc <= w_redir_pc;
                    end else if (r_level < (AW+1)'(DEPTH)) begin
                        r_stb   <= 1'b1;
                        r_adr   <= (XLEN-2)'(r_fetch_pc >> 2);
                        r_state <= FETCH;
                    end
                end
                FETCH, DISCARD: begin
                    if (w_term) begin
                        r_stb     <= 1'b0;
                        r_adr     <= '0;
                        r_state   <= IDLE;
                        r_redir_v <= 1'b0;
                        if (w_push)
                            r_fetch_pc <= r_fetch_pc + XLEN'(4);
                        else if (w_rd_v)
                            r_fetch_pc <= w_rd_pc;
                    end else if (w_abort) begin
                        // bus must still be terminated; remember where to resume
                        if (redirect_i) begin
                            r_redir_v  <= 1'b1;
                            r_redir_pc <= w_redir_pc;
                        end
                        r_state <= DISCARD;
                    end
                end
                VECTOR: begin
                    if (w_term) begin
                        r_stb   <= 1'b0;
                        r_adr   <= '0;
                        r_state <= IDLE;
                        if (bus.ack_i) begin
                            r_int_pc   <= bus.master_dat_i;
                            r_int_wr   <= 1'b1;
                            r_fetch_pc <= bus.master_dat_i;
                        end
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_ins[r_wptr] <= bus.ack_i ? bus.master_dat_i[ILEN-1:0] : '0;
            r_mem_pc[r_wptr]  <= r_fetch_pc;
            r_mem_flt[r_wptr] <= ~bus.ack_i;
        end
    end

    assign valid_o              = r_level != '0;
    assign instruction_o        = valid_o ? r_mem_ins[r_rptr] : '0;
    assign instr_pc_o           = valid_o ? r_mem_pc[r_rptr] : '0;
    assign fault_o              = valid_o & r_mem_flt[r_rptr];
    assign level_o              = r_level;
    assign interrupt_pc_o       = r_int_pc;
    assign interrupt_pc_write_o = r_int_wr;
    assign bus.ctrl_req_o       = r_stb;
    assign bus.cyc_o            = r_stb;
    assign bus.stb_o            = r_stb;
    assign bus.sel_o            = 4'hF;
    assign bus.adr_o            = r_adr;
endmodule
